// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------
// cpu_pkg : shared CPU encodings (branch select, fetch FSM, widths)
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int INST_W = 16;

  localparam logic [2:0] BS_BEQ  = 3'b000;
  localparam logic [2:0] BS_BNE  = 3'b001;
  localparam logic [2:0] BS_JR   = 3'b010;
  localparam logic [2:0] BS_JAL  = 3'b011;
  localparam logic [2:0] BS_NONE = 3'b100;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_STOP = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/next_pc_calc.sv
// ---------------------------------------------------------------
// next_pc_calc : successor PC from branch select, zero flag, offset, RA
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [2:0]        bs,
  input  logic              zero,
  input  logic [5:0]        off,
  input  logic [INST_W-1:0] ra,
  input  logic [PC_W-1:0]   pc_out,
  output logic [PC_W-1:0]   next_pc
);

  logic [PC_W-1:0] w_seq;
  logic [PC_W-1:0] w_taken;

  assign w_seq   = pc_out + PC_W'(1);
  assign w_taken = w_seq + {{(PC_W-6){off[5]}}, off};

  // Only the low PC_W bits of the register value form a jump target.
  generate
    if (PC_W < INST_W) begin : g_ra_hi
      logic w_unused_ra_hi;
      assign w_unused_ra_hi = ^ra[INST_W-1:PC_W];
    end
  endgenerate

  always_comb begin
    next_pc = w_seq;
    case (bs)
      BS_BEQ:         next_pc = zero ? w_taken : w_seq;
      BS_BNE:         next_pc = zero ? w_seq : w_taken;
      BS_JR, BS_JAL:  next_pc = ra[PC_W-1:0];
      BS_NONE:        next_pc = w_seq;
      default:        next_pc = w_seq;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------
// fetch_unit : PC ownership, imem req/ack fetch, redirect, retire count
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic [PC_W-1:0]   pc_out,
  output logic [PC_W-1:0]   pc_link,
  input  logic              ex_done,
  input  logic [2:0]        bs,
  input  logic [5:0]        off,
  input  logic              zero,
  input  logic [INST_W-1:0] ra,
  input  logic              halt,
  input  logic              resume,
  output logic              halted,
  output logic [15:0]       retired
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_pc_out;
  logic [INST_W-1:0] r_inst;
  logic              r_inst_valid;
  logic [15:0]       r_retired;
  logic [PC_W-1:0]   w_next_pc;
  logic              w_fetch;
  logic              w_retire;

  assign w_fetch  = (r_state == ST_REQ)  && imem_ack;
  assign w_retire = (r_state == ST_HOLD) && ex_done;

  next_pc_calc #(.PC_W(PC_W)) u_next_pc (
    .bs      (bs),
    .zero    (zero),
    .off     (off),
    .ra      (ra),
    .pc_out  (r_pc_out),
    .next_pc (w_next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_REQ;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_REQ:  if (imem_ack) w_state_nxt = ST_HOLD;
      ST_HOLD: if (ex_done)  w_state_nxt = halt ? ST_STOP : ST_REQ;
      ST_STOP: if (resume)   w_state_nxt = ST_REQ;
      default: w_state_nxt = ST_REQ;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    halted   = 1'b0;
    case (r_state)
      ST_REQ:  imem_req = 1'b1;
      ST_STOP: halted   = 1'b1;
      default: ;
    endcase
  end

  // A halting instruction still redirects the PC; resume continues from there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_pc_out     <= RESET_PC;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
      r_retired    <= '0;
    end else begin
      if (w_fetch) begin
        r_inst       <= imem_data;
        r_inst_valid <= 1'b1;
        r_pc_out     <= r_pc;
      end
      if (w_retire) begin
        r_inst_valid <= 1'b0;
        r_pc         <= w_next_pc;
        r_retired    <= r_retired + 16'd1;
      end
    end
  end

  assign imem_addr  = r_pc;
  assign inst       = r_inst;
  assign inst_valid = r_inst_valid;
  assign pc_out     = r_pc_out;
  assign pc_link    = r_pc_out + PC_W'(1);
  assign retired    = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------
// tb_fetch_unit : directed self-checking bench for fetch_unit
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] inst;
  logic        inst_valid;
  logic [7:0]  pc_out;
  logic [7:0]  pc_link;
  logic        ex_done;
  logic [2:0]  bs;
  logic [5:0]  off;
  logic        zero;
  logic [15:0] ra;
  logic        halt;
  logic        resume;
  logic        halted;
  logic [15:0] retired;

  logic        auto_ack;
  logic        man_ack;
  logic [15:0] data_xor;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Memory returns 0xA5 in the high byte and the address in the low byte.
  assign imem_ack  = auto_ack ? imem_req : man_ack;
  assign imem_data = {8'hA5, imem_addr} ^ data_xor;

  fetch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc_out     (pc_out),
    .pc_link    (pc_link),
    .ex_done    (ex_done),
    .bs         (bs),
    .off        (off),
    .zero       (zero),
    .ra         (ra),
    .halt       (halt),
    .resume     (resume),
    .halted     (halted),
    .retired    (retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!inst_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!inst_valid) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic retire(input logic [2:0] b, input logic z, input logic [5:0] o,
                        input logic [15:0] r, input logic h);
    ex_done = 1'b1; bs = b; zero = z; off = o; ra = r; halt = h;
    @(negedge clk);
    ex_done = 1'b0; bs = 3'b100; zero = 1'b0; off = '0; ra = '0; halt = 1'b0;
  endtask

  initial begin
    int bad;
    rst = 1'b1; auto_ack = 1'b0; man_ack = 1'b0; data_xor = '0;
    ex_done = 1'b0; bs = 3'b100; off = '0; zero = 1'b0; ra = '0;
    halt = 1'b0; resume = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_inst",       {16'd0, inst},      32'h0);
    check("rst_valid",      {31'd0, inst_valid}, 32'd0);
    check("rst_pc_out",     {24'd0, pc_out},    32'h00);
    check("rst_pc_link",    {24'd0, pc_link},   32'h01);
    check("rst_halted",     {31'd0, halted},    32'd0);
    check("rst_retired",    {16'd0, retired},   32'd0);
    check("rst_req",        {31'd0, imem_req},  32'd1);

    // Sequential fetch with zero-wait memory.
    rst = 1'b0; auto_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_valid();
      check("seq_pc_out", {24'd0, pc_out}, i);
      check("seq_inst",   {16'd0, inst},   32'hA500 | i);
      retire(3'b100, 1'b0, 6'd0, 16'd0, 1'b0);
    end
    check("seq_retired", {16'd0, retired},   32'd4);
    check("seq_addr4",   {24'd0, imem_addr}, 32'h04);
    check("seq_valid0",  {31'd0, inst_valid}, 32'd0);

    // BEQ taken / not taken from PC_OUT=10.
    wait_valid();
    retire(3'b011, 1'b0, 6'd0, 16'd10, 1'b0);
    wait_valid();
    check("jal_pc10",  {24'd0, pc_out},  32'd10);
    check("link_11",   {24'd0, pc_link}, 32'd11);
    retire(3'b000, 1'b1, 6'b111100, 16'd0, 1'b0);
    check("beq_t_addr", {24'd0, imem_addr}, 32'd7);
    wait_valid();
    retire(3'b011, 1'b0, 6'd0, 16'd10, 1'b0);
    wait_valid();
    retire(3'b000, 1'b0, 6'b111100, 16'd0, 1'b0);
    check("beq_nt_addr", {24'd0, imem_addr}, 32'd11);

    // BNE with wrap, then JAL to RA low byte.
    wait_valid();
    retire(3'b011, 1'b0, 6'd0, 16'h00F0, 1'b0);
    wait_valid();
    check("jal_pcF0", {24'd0, pc_out}, 32'hF0);
    retire(3'b001, 1'b0, 6'd31, 16'd0, 1'b0);
    check("bne_wrap_addr", {24'd0, imem_addr}, 32'h10);
    wait_valid();
    check("hold_link", {24'd0, pc_link}, 32'h11);
    retire(3'b011, 1'b0, 6'd0, 16'h1234, 1'b0);
    check("jal_addr34", {24'd0, imem_addr}, 32'h34);

    // 3-cycle memory wait.
    wait_valid();
    auto_ack = 1'b0;
    retire(3'b100, 1'b0, 6'd0, 16'd0, 1'b0);
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (!imem_req || imem_addr != 8'h35 || inst_valid) bad++;
      if (c == 3) man_ack = 1'b1;
      else @(negedge clk);
    end
    check("wait_req_stable", bad, 32'd0);
    @(negedge clk);
    man_ack = 1'b0;
    check("wait_valid", {31'd0, inst_valid}, 32'd1);
    check("wait_inst",  {16'd0, inst},       32'hA535);
    man_ack = 1'b1; data_xor = 16'h0F0F;
    @(negedge clk);
    man_ack = 1'b0; data_xor = '0;
    check("spur_ack_inst", {16'd0, inst}, 32'hA535);
    check("spur_ack_pc",   {24'd0, pc_out}, 32'h35);

    // HALT at PC_OUT=5, then RESUME.
    auto_ack = 1'b1;
    retire(3'b011, 1'b0, 6'd0, 16'd5, 1'b0);
    wait_valid();
    check("halt_pc5", {24'd0, pc_out}, 32'd5);
    retire(3'b100, 1'b0, 6'd0, 16'd0, 1'b1);
    check("halted_1",      {31'd0, halted},  32'd1);
    check("halt_retired",  {16'd0, retired}, 32'd14);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (imem_req || !halted) bad++;
      @(negedge clk);
    end
    check("halt_no_req", bad, 32'd0);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    check("resume_req",    {31'd0, imem_req},  32'd1);
    check("resume_addr",   {24'd0, imem_addr}, 32'd6);
    check("resume_halted", {31'd0, halted},    32'd0);

    // Asynchronous reset while waiting on ACK at address 9.
    wait_valid();
    auto_ack = 1'b0;
    retire(3'b010, 1'b0, 6'd0, 16'd9, 1'b0);
    check("pre_rst_addr",    {24'd0, imem_addr}, 32'd9);
    check("pre_rst_retired", {16'd0, retired},   32'd15);
    #2 rst = 1'b1;
    #1;
    check("arst_addr",    {24'd0, imem_addr}, 32'd0);
    check("arst_retired", {16'd0, retired},   32'd0);
    check("arst_pc_link", {24'd0, pc_link},   32'd1);
    check("arst_req",     {31'd0, imem_req},  32'd1);
    @(negedge clk);
    rst = 1'b0; auto_ack = 1'b1;
    @(negedge clk);
    check("post_rst_valid", {31'd0, inst_valid}, 32'd1);
    check("post_rst_pc",    {24'd0, pc_out},     32'd0);
    check("post_rst_ret",   {16'd0, retired},    32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
